// File: rtl/vend_fsm_multi.sv
// Multi-product vending controller: coin credit accumulation, per-product stock,
// cancel/refund, inactivity auto-refund and a fixed-length dispense hold.
module vend_fsm_multi #(
    parameter int N_PROD     = 4,
    parameter int COIN1      = 30,
    parameter int COIN2      = 50,
    parameter int COIN3      = 100,
    parameter int PRICE_BASE = 60,
    parameter int PRICE_STEP = 10,
    parameter int MAX_CREDIT = 300,
    parameter int CREDIT_W   = 10,
    parameter int STOCK_INIT = 8,
    parameter int STOCK_W    = 4,
    parameter int TIMEOUT    = 1000,
    parameter int VEND_HOLD  = 4,
    localparam int SEL_W     = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          coin_in,
    input  logic                sel_valid,
    input  logic [SEL_W-1:0]    sel_id,
    input  logic                cancel,
    input  logic                restock,
    output logic                purchase,
    output logic [SEL_W-1:0]    purchase_id,
    output logic                ret_valid,
    output logic [CREDIT_W-1:0] ret,
    output logic [CREDIT_W-1:0] credit,
    output logic [N_PROD-1:0]   sold_out,
    output logic                accepting
);

    localparam int TIMER_W = $clog2(TIMEOUT + 1);
    localparam int HOLD_W  = (VEND_HOLD > 1) ? $clog2(VEND_HOLD) : 1;

    localparam logic [SEL_W:0]      N_PROD_L   = (SEL_W + 1)'(N_PROD);
    localparam logic [CREDIT_W:0]   MAX_CRED_L = (CREDIT_W + 1)'(MAX_CREDIT);
    localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(TIMEOUT - 1);
    localparam logic [HOLD_W-1:0]   HOLD_LAST  = HOLD_W'(VEND_HOLD - 1);
    localparam logic [STOCK_W-1:0]  STOCK_FULL = STOCK_W'(STOCK_INIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CREDIT,
        S_DISPENSE
    } state_t;

    state_t               state_q, state_d;
    logic [CREDIT_W-1:0]  credit_q, credit_d;
    logic [CREDIT_W-1:0]  ret_q, ret_d;
    logic                 ret_valid_q, ret_valid_d;
    logic                 purchase_q, purchase_d;
    logic [SEL_W-1:0]     purchase_id_q, purchase_id_d;
    logic [STOCK_W-1:0]   stock_q [N_PROD];
    logic [STOCK_W-1:0]   stock_d [N_PROD];
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;

    logic [CREDIT_W-1:0]  cv;
    logic [CREDIT_W:0]    sum;
    logic                 over;
    logic [CREDIT_W-1:0]  eff;
    logic [CREDIT_W-1:0]  bounce;
    logic                 sel_in_range;
    logic [SEL_W-1:0]     sel_idx;
    logic [CREDIT_W-1:0]  price;
    logic                 can_buy;
    logic                 activity;

    // Coin valuation and credit-ceiling check shared by every non-dispense path.
    always_comb begin
        unique case (coin_in)
            2'b01:   cv = CREDIT_W'(COIN1);
            2'b10:   cv = CREDIT_W'(COIN2);
            2'b11:   cv = CREDIT_W'(COIN3);
            default: cv = '0;
        endcase
        sum          = {1'b0, credit_q} + {1'b0, cv};
        over         = (sum > MAX_CRED_L);
        eff          = over ? credit_q : sum[CREDIT_W-1:0];
        bounce       = over ? cv : '0;
        sel_in_range = ({1'b0, sel_id} < N_PROD_L);
        sel_idx      = sel_in_range ? sel_id : '0;
        price        = CREDIT_W'(PRICE_BASE) + CREDIT_W'(PRICE_STEP) * CREDIT_W'(sel_idx);
        can_buy      = sel_valid && sel_in_range && (stock_q[sel_idx] != '0) && (eff >= price);
        activity     = (coin_in != 2'b00) || sel_valid || cancel;
    end

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_d       = state_q;
        credit_d      = credit_q;
        ret_d         = '0;
        purchase_d    = 1'b0;
        purchase_id_d = purchase_id_q;
        stock_d       = stock_q;
        timer_d       = '0;
        hold_d        = '0;

        unique case (state_q)
            S_DISPENSE: begin
                ret_d = cv;
                if (hold_q == HOLD_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                if (cancel) begin
                    ret_d    = eff + bounce;
                    credit_d = '0;
                    state_d  = S_IDLE;
                end else if (can_buy) begin
                    purchase_d       = 1'b1;
                    purchase_id_d    = sel_idx;
                    stock_d[sel_idx] = stock_q[sel_idx] - 1'b1;
                    ret_d            = eff - price + bounce;
                    credit_d         = '0;
                    state_d          = S_DISPENSE;
                end else begin
                    credit_d = eff;
                    ret_d    = bounce;
                    if (eff == '0) begin
                        state_d = S_IDLE;
                    end else if (activity) begin
                        state_d = S_CREDIT;
                    end else if (timer_q == TIMER_LAST) begin
                        // Inactivity expired: hand back everything held.
                        ret_d    = credit_q;
                        credit_d = '0;
                        state_d  = S_IDLE;
                    end else begin
                        timer_d = timer_q + 1'b1;
                        state_d = S_CREDIT;
                    end
                end

                if (state_q == S_IDLE && coin_in == 2'b00 && restock) begin
                    for (int i = 0; i < N_PROD; i++) stock_d[i] = STOCK_FULL;
                end
            end
        endcase

        ret_valid_d = (ret_d != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            credit_q      <= '0;
            ret_q         <= '0;
            ret_valid_q   <= 1'b0;
            purchase_q    <= 1'b0;
            purchase_id_q <= '0;
            timer_q       <= '0;
            hold_q        <= '0;
            // NOTE: the stock array is architectural state with a defined reset value, so unlike a RAM it is reset here.
            for (int i = 0; i < N_PROD; i++) stock_q[i] <= STOCK_FULL;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q       <= state_d;
            credit_q      <= credit_d;
            ret_q         <= ret_d;
            ret_valid_q   <= ret_valid_d;
            purchase_q    <= purchase_d;
            purchase_id_q <= purchase_id_d;
            timer_q       <= timer_d;
            hold_q        <= hold_d;
            for (int i = 0; i < N_PROD; i++) stock_q[i] <= stock_d[i];
        end
    end

    always_comb begin
        for (int i = 0; i < N_PROD; i++) sold_out[i] = (stock_q[i] == '0);
    end

    assign purchase    = purchase_q;
    assign purchase_id = purchase_id_q;
    assign ret_valid   = ret_valid_q;
    assign ret         = ret_q;
    assign credit      = credit_q;
    assign accepting   = (state_q != S_DISPENSE);

endmodule

// File: tb/tb_vend_fsm_multi.sv
// Directed bench for vend_fsm_multi at default parameters; expectations hand-derived
// from coin values 30/50/100, prices 60/70/80/90, ceiling 300, stock 8, timeout 1000.
module tb_vend_fsm_multi;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] coin_in;
    logic       sel_valid;
    logic [1:0] sel_id;
    logic       cancel;
    logic       restock;
    logic       purchase;
    logic [1:0] purchase_id;
    logic       ret_valid;
    logic [9:0] ret;
    logic [9:0] credit;
    logic [3:0] sold_out;
    logic       accepting;

    int n_cmp  = 0;
    int n_fail = 0;

    vend_fsm_multi dut (
        .clk         (clk),
        .reset       (reset),
        .coin_in     (coin_in),
        .sel_valid   (sel_valid),
        .sel_id      (sel_id),
        .cancel      (cancel),
        .restock     (restock),
        .purchase    (purchase),
        .purchase_id (purchase_id),
        .ret_valid   (ret_valid),
        .ret         (ret),
        .credit      (credit),
        .sold_out    (sold_out),
        .accepting   (accepting)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of inputs, let the edge sample them, then return inputs to quiet.
    task automatic apply(input logic [1:0] c, input logic sv, input logic [1:0] id,
                         input logic cn, input logic rs);
        coin_in   = c;
        sel_valid = sv;
        sel_id    = id;
        cancel    = cn;
        restock   = rs;
        tick();
        coin_in   = 2'b00;
        sel_valid = 1'b0;
        sel_id    = 2'd0;
        cancel    = 1'b0;
        restock   = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic ep, input int eret, input int ecred);
        check({tag, ".purchase"},  32'(purchase),  32'(ep));
        check({tag, ".ret_valid"}, 32'(ret_valid), 32'(eret != 0));
        check({tag, ".ret"},       32'(ret),       32'(eret));
        check({tag, ".credit"},    32'(credit),    32'(ecred));
    endtask

    // Called right after the purchase edge: three more cycles not accepting, then back.
    task automatic finish_dispense(input string tag);
        for (int i = 0; i < 3; i++) begin
            tick();
            check({tag, ".hold_accepting"}, 32'(accepting), 32'd0);
        end
        tick();
        check({tag, ".release_accepting"}, 32'(accepting), 32'd1);
    endtask

    initial begin
        reset = 1'b1; coin_in = 2'b00; sel_valid = 1'b0; sel_id = 2'd0;
        cancel = 1'b0; restock = 1'b0;
        tick();
        tick();
        expect_out("rst", 1'b0, 0, 0);
        check("rst.purchase_id", 32'(purchase_id), 32'd0);
        check("rst.sold_out",    32'(sold_out),    32'd0);
        check("rst.accepting",   32'(accepting),   32'd1);
        reset = 1'b0;

        // 30 + 30 then buy product 0 at 60, exact change
        apply(2'b01, 1'b0, 2'd0, 1'b0, 1'b0);
        expect_out("c30", 1'b0, 0, 30);
        apply(2'b01, 1'b0, 2'd0, 1'b0, 1'b0);
        expect_out("c60", 1'b0, 0, 60);
        apply(2'b00, 1'b1, 2'd0, 1'b0, 1'b0);
        expect_out("buy0", 1'b1, 0, 0);
        check("buy0.id",        32'(purchase_id), 32'd0);
        check("buy0.accepting", 32'(accepting),   32'd0);
        tick();
        check("buy0.pulse_end", 32'(purchase), 32'd0);
        check("buy0.id_held",   32'(purchase_id), 32'd0);
        check("buy0.hold1",     32'(accepting), 32'd0);
        tick();
        tick();
        check("buy0.hold3", 32'(accepting), 32'd0);
        tick();
        check("buy0.release", 32'(accepting), 32'd1);

        // 100 then product 1 at 70: change 30
        apply(2'b11, 1'b0, 2'd0, 1'b0, 1'b0);
        expect_out("c100", 1'b0, 0, 100);
        apply(2'b00, 1'b1, 2'd1, 1'b0, 1'b0);
        expect_out("buy1", 1'b1, 30, 0);
        check("buy1.id", 32'(purchase_id), 32'd1);
        finish_dispense("buy1");

        // cancel after a coin, coin+cancel together, cancel with no credit
        apply(2'b10, 1'b0, 2'd0, 1'b0, 1'b0);
        expect_out("c50", 1'b0, 0, 50);
        apply(2'b00, 1'b0, 2'd0, 1'b1, 1'b0);
        expect_out("cancel50", 1'b0, 50, 0);
        apply(2'b10, 1'b0, 2'd0, 1'b1, 1'b0);
        expect_out("coin_cancel", 1'b0, 50, 0);
        apply(2'b00, 1'b0, 2'd0, 1'b1, 1'b0);
        expect_out("cancel_empty", 1'b0, 0, 0);

        // ceiling: exactly 300 accepted, then a coin bounced
        apply(2'b11, 1'b0, 2'd0, 1'b0, 1'b0);
        apply(2'b11, 1'b0, 2'd0, 1'b0, 1'b0);
        apply(2'b10, 1'b0, 2'd0, 1'b0, 1'b0);
        expect_out("c250", 1'b0, 0, 250);
        apply(2'b10, 1'b0, 2'd0, 1'b0, 1'b0);
        expect_out("c300_exact", 1'b0, 0, 300);
        apply(2'b01, 1'b0, 2'd0, 1'b0, 1'b0);
        expect_out("bounce30", 1'b0, 30, 300);
        apply(2'b00, 1'b0, 2'd0, 1'b1, 1'b0);
        expect_out("cancel300", 1'b0, 300, 0);

        // 280, then 50 bounced; then coin 100 (bounced) with buy of product 3 at 90
        apply(2'b11, 1'b0, 2'd0, 1'b0, 1'b0);
        apply(2'b11, 1'b0, 2'd0, 1'b0, 1'b0);
        apply(2'b10, 1'b0, 2'd0, 1'b0, 1'b0);
        apply(2'b01, 1'b0, 2'd0, 1'b0, 1'b0);
        expect_out("c280", 1'b0, 0, 280);
        apply(2'b10, 1'b0, 2'd0, 1'b0, 1'b0);
        expect_out("bounce50", 1'b0, 50, 280);
        apply(2'b11, 1'b1, 2'd3, 1'b0, 1'b0);
        expect_out("buy3_bounce", 1'b1, 290, 0);
        check("buy3.id", 32'(purchase_id), 32'd3);
        apply(2'b10, 1'b0, 2'd0, 1'b0, 1'b0);
        expect_out("disp_coin", 1'b0, 50, 0);
        check("disp_coin.accepting", 32'(accepting), 32'd0);
        apply(2'b00, 1'b1, 2'd0, 1'b1, 1'b0);
        expect_out("disp_sel_cancel", 1'b0, 0, 0);
        tick();
        check("buy3.hold3", 32'(accepting), 32'd0);
        tick();
        check("buy3.release", 32'(accepting), 32'd1);

        // drain product 2 (price 80) eight times
        for (int n = 0; n < 8; n++) begin
            apply(2'b10, 1'b0, 2'd0, 1'b0, 1'b0);
            apply(2'b01, 1'b0, 2'd0, 1'b0, 1'b0);
            apply(2'b00, 1'b1, 2'd2, 1'b0, 1'b0);
            expect_out($sformatf("buy2_%0d", n), 1'b1, 0, 0);
            repeat (4) tick();
        end
        check("drained.sold_out", 32'(sold_out), 32'b0100);
        apply(2'b11, 1'b0, 2'd0, 1'b0, 1'b0);
        apply(2'b00, 1'b1, 2'd2, 1'b0, 1'b0);
        expect_out("soldout_sel", 1'b0, 0, 100);
        check("soldout_sel.accepting", 32'(accepting), 32'd1);
        apply(2'b00, 1'b0, 2'd0, 1'b0, 1'b1);
        check("restock_in_credit", 32'(sold_out), 32'b0100);
        apply(2'b00, 1'b0, 2'd0, 1'b1, 1'b0);
        expect_out("cancel100", 1'b0, 100, 0);
        apply(2'b01, 1'b0, 2'd0, 1'b0, 1'b1);
        check("restock_with_coin", 32'(sold_out), 32'b0100);
        check("restock_with_coin.credit", 32'(credit), 32'd30);
        apply(2'b00, 1'b0, 2'd0, 1'b1, 1'b0);
        expect_out("cancel30", 1'b0, 30, 0);
        apply(2'b00, 1'b0, 2'd0, 1'b0, 1'b1);
        check("restock_idle", 32'(sold_out), 32'b0000);

        // short credit select ignored, then inactivity auto-refund after 1000 quiet cycles
        apply(2'b01, 1'b0, 2'd0, 1'b0, 1'b0);
        apply(2'b00, 1'b1, 2'd0, 1'b0, 1'b0);
        expect_out("short_sel", 1'b0, 0, 30);
        repeat (999) tick();
        expect_out("idle999", 1'b0, 0, 30);
        tick();
        expect_out("timeout", 1'b0, 30, 0);
        tick();
        expect_out("after_timeout", 1'b0, 0, 0);

        // reset mid-credit, then reset mid-dispense
        apply(2'b10, 1'b0, 2'd0, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expect_out("rst_credit", 1'b0, 0, 0);
        apply(2'b11, 1'b0, 2'd0, 1'b0, 1'b0);
        apply(2'b00, 1'b1, 2'd1, 1'b0, 1'b0);
        expect_out("buy1b", 1'b1, 30, 0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expect_out("rst_disp", 1'b0, 0, 0);
        check("rst_disp.purchase_id", 32'(purchase_id), 32'd0);
        check("rst_disp.accepting",   32'(accepting),   32'd1);
        check("rst_disp.sold_out",    32'(sold_out),    32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
